// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide sequencer holding HI/LO; define MDU_MADD_EN to add signed madd (mdop 9)
module mdu_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  mdop,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        D_md,
   output logic        start,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic [31:0] rd_data,
   output logic        stall
);
   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [63:0]   pend_q, pend_d;
   logic [31:0]   hi_q, hi_d, lo_q, lo_d;
   logic          madd_q, madd_d;
   logic          is_madd, is_mul, is_md;
   logic [63:0]   smul, umul, res;
   logic [31:0]   sq, sr, uq, ur;

`ifdef MDU_MADD_EN
   assign is_madd = (mdop == 4'd9);
`else
   assign is_madd = 1'b0;
`endif

   assign is_mul  = (mdop == 4'd1) || (mdop == 4'd3) || is_madd;
   assign is_md   = is_mul || (mdop == 4'd2) || (mdop == 4'd4);
   assign busy    = (state_q == RUN);
   assign start   = is_md && !busy;
   assign stall   = D_md && (start || busy);
   assign HI      = hi_q;
   assign LO      = lo_q;
   assign rd_data = (mdop == 4'd5) ? hi_q : (mdop == 4'd6) ? lo_q : 32'd0;

   assign smul = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
   assign umul = {32'd0, A} * {32'd0, B};
   assign sq   = $signed(A) / $signed(B);
   assign sr   = $signed(A) % $signed(B);
   assign uq   = A / B;
   assign ur   = A % B;

   // madd latches the bare product; the accumulate happens at completion against live HI/LO
   assign res = ((mdop == 4'd1) || is_madd) ? smul :
                (mdop == 4'd3)              ? umul :
                (B == 32'd0)                ? {hi_q, lo_q} :
                (mdop == 4'd2)              ? {sr, sq} : {ur, uq};

   // next-state: launch, count down and retire, or serve mthi/mtlo when idle
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      madd_d  = madd_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      if (start) begin
         pend_d  = res;
         madd_d  = is_madd;
         cnt_d   = is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
         state_d = RUN;
      end else if (busy) begin
         cnt_d = cnt_q - CW'(1);
         if (cnt_q == CW'(1)) begin
            {hi_d, lo_d} = madd_q ? {hi_q, lo_q} + pend_q : pend_q;
            state_d      = IDLE;
         end
      end else begin
         hi_d = (mdop == 4'd7) ? A : hi_q;
         lo_d = (mdop == 4'd8) ? A : lo_q;
      end
   end

   // state register with synchronous clear of everything, including any pending result
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         pend_q  <= '0;
         madd_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         madd_q  <= madd_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: scoreboard bench for mdu_ctrl; define MDU_MADD_EN to exercise madd
module tb_mdu_ctrl;
   logic        clk = 1'b0;
   logic        reset, D_md;
   logic [3:0]  mdop;
   logic [31:0] A, B;
   logic        start, busy, stall;
   logic [31:0] HI, LO, rd_data;
   int          n_vec = 0;
   int          n_err = 0;
   logic [63:0] sb[$];

   mdu_ctrl dut (
      .clk(clk), .reset(reset), .mdop(mdop), .A(A), .B(B), .D_md(D_md),
      .start(start), .busy(busy), .HI(HI), .LO(LO), .rd_data(rd_data), .stall(stall)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int n, input logic dmd,
                         input int inj, input logic [3:0] iop);
      int cyc  = 0;
      int scnt = 0;
      @(negedge clk);
      mdop = op; A = a; B = b; D_md = dmd;
      #1;
      chk("start", 64'(start), 64'd1);
      scnt += int'(stall);
      sb.push_back(exp);
      @(posedge clk);
      #1;
      mdop = 4'd0;
      while (busy && cyc < 100) begin
         scnt += int'(stall);
         if (cyc == inj) begin
            mdop = iop; A = 32'hDEADBEEF; B = 32'h5;
            #1;
            chk("ign_start", 64'(start), 64'd0);
         end
         @(posedge clk);
         #1;
         mdop = 4'd0;
         cyc++;
      end
      chk("busy_len", 64'(cyc), 64'(n));
      chk("stall_len", 64'(scnt), dmd ? 64'(n + 1) : 64'd0);
      chk("stall_idle", 64'(stall), 64'd0);
      chk("result", {HI, LO}, sb.pop_front());
      D_md = 1'b0;
   endtask

   initial begin
      logic [31:0]        ra, rb;
      logic signed [63:0] sa, sbv;
      reset = 1'b1; D_md = 1'b1; mdop = 4'd0; A = '0; B = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_start", 64'(start), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_stall", 64'(stall), 64'd0);
      chk("rst_rd", 64'(rd_data), 64'd0);
      chk("rst_hilo", {HI, LO}, 64'd0);
      reset = 1'b0; D_md = 1'b0;

      launch(4'd1, 32'hFFFFFFFE, 32'd3, 64'hFFFFFFFF_FFFFFFFA, 5, 1'b0, -1, 4'd0);
      launch(4'd3, 32'hFFFFFFFF, 32'd2, 64'h00000001_FFFFFFFE, 5, 1'b0, -1, 4'd0);
      @(negedge clk); mdop = 4'd5; #1;
      chk("mfhi", 64'(rd_data), 64'h1);
      mdop = 4'd6; #1;
      chk("mflo", 64'(rd_data), 64'hFFFFFFFE);
      mdop = 4'd0; #1;
      chk("rd_none", 64'(rd_data), 64'd0);

      launch(4'd2, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 10, 1'b1, -1, 4'd0);
      launch(4'd4, 32'd7, 32'd0, 64'hFFFFFFFF_FFFFFFFD, 10, 1'b0, -1, 4'd0);
      launch(4'd2, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 10, 1'b0, -1, 4'd0);

      @(negedge clk); mdop = 4'd7; A = 32'h12345678;
      @(negedge clk); mdop = 4'd8; A = 32'h9ABCDEF0;
      @(negedge clk); mdop = 4'd0;
      chk("mthi_mtlo", {HI, LO}, 64'h12345678_9ABCDEF0);

      launch(4'd1, 32'd3, 32'd4, 64'h0000000C, 5, 1'b1, 2, 4'd1);
      launch(4'd4, 32'd100, 32'd7, 64'h00000002_0000000E, 10, 1'b0, 4, 4'd7);

      for (int i = 0; i < 3; i++) begin
         ra = $urandom; rb = $urandom;
         sa = {{32{ra[31]}}, ra}; sbv = {{32{rb[31]}}, rb};
         launch(4'd1, ra, rb, 64'(sa * sbv), 5, 1'($urandom_range(1)), -1, 4'd0);
         ra = $urandom; rb = $urandom;
         launch(4'd3, ra, rb, {32'd0, ra} * {32'd0, rb}, 5, 1'b0, -1, 4'd0);
      end

      launch(4'd4, 32'd100, 32'd7, 64'h00000002_0000000E, 10, 1'b0, -1, 4'd0);
      @(negedge clk); mdop = 4'd1; A = 32'd3; B = 32'd4;
      @(negedge clk); mdop = 4'd0;
      repeat (2) @(negedge clk);
      chk("mid_busy", 64'(busy), 64'd1);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_mid_busy", 64'(busy), 64'd0);
      chk("rst_mid_hilo", {HI, LO}, 64'd0);
      reset = 1'b0;
      repeat (8) @(negedge clk);
      chk("rst_no_result", {HI, LO}, 64'd0);
      chk("rst_idle", 64'(busy), 64'd0);

      @(negedge clk); mdop = 4'd8; A = 32'd5;
      @(negedge clk); mdop = 4'd0;
`ifdef MDU_MADD_EN
      launch(4'd9, 32'd3, 32'd4, 64'h00000000_00000011, 5, 1'b1, -1, 4'd0);
`else
      @(negedge clk); mdop = 4'd9; A = 32'd7; B = 32'd4; #1;
      chk("op9_start", 64'(start), 64'd0);
      chk("op9_rd", 64'(rd_data), 64'd0);
      @(negedge clk); mdop = 4'd0;
      chk("op9_busy", 64'(busy), 64'd0);
      chk("op9_hilo", {HI, LO}, 64'h00000000_00000005);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
